fb_port_scheduler: RTL and testbench

- Time-shares the single-port tile-map RAM behind the VGA sync generator between two requesters.
- Requester 1 is the video fetch: one tile code per 8x8 character cell, hard real-time, always has priority.
- Requester 2 is the RTC/interface writer that updates displayed digits, using a req/ack handshake.
- Sits between the sync generator (px_X, px_Y, video_on, pixel strobe) and the character-ROM/colour stage.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/tile_addr_calc.sv | 20 ++
 rtl/fb_port_scheduler.sv | 150 +++++++++++++++
 tb/tb_fb_port_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: tile geometry, sync timing and the tile-map port scheduler state encoding.
package vga_pkg;

  // Tile geometry for a 640x480 screen built from 8x8 character cells.
  localparam int TILE_SIZE  = 8;
  localparam int TILE_SHIFT = 3;
  localparam int TILE_COLS  = 80;
  localparam int TILE_ROWS  = 60;
  localparam int TILE_ADDR_W = 13;
  localparam int TILE_DATA_W = 8;

  // 640x480@60 timing, shared with the sync generator.
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Tile-map port ownership: idle, video read issue, video capture, interface write.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VRD  = 2'd1,
    ST_VCAP = 2'd2,
    ST_WR   = 2'd3
  } sched_state_t;

  // True on the first pixel column of a character cell.
  function automatic logic tile_x_aligned(input logic [9:0] px);
    return (px[2:0] == 3'd0);
  endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Combinational tile-map address: row * COLS + col.
// For the 80-column screen this is (row << 6) + (row << 4) + col, no multiplier needed.
module tile_addr_calc #(
  parameter int COLS   = 80,
  parameter int ADDR_W = 13
) (
  input  logic [6:0]        row,
  input  logic [6:0]        col,
  output logic [ADDR_W-1:0] addr
);

  generate
    if (COLS == 80) begin : g_shift_add
      assign addr = ADDR_W'({row, 6'b000000}) + ADDR_W'({row, 4'b0000}) + ADDR_W'(col);
    end else begin : g_generic
      assign addr = ADDR_W'((int'(row) * COLS) + int'(col));
    end
  endgenerate

endmodule

// File: rtl/fb_port_scheduler.sv
// Time-shares the single-port tile-map RAM between the video fetch (hard real-time,
// always wins) and the interface writer (req/ack, one cycle per write).
module fb_port_scheduler
  import vga_pkg::*;
#(
  parameter int COLS          = TILE_COLS,
  parameter int ROWS          = TILE_ROWS,
  parameter int ADDR_W        = TILE_ADDR_W,
  parameter int DATA_W        = TILE_DATA_W,
  parameter bit WR_BLANK_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_tick,
  input  logic [9:0]        px_X,
  input  logic [9:0]        px_Y,
  input  logic              video_on,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tile_code,
  output logic              tile_valid
);

  sched_state_t      state;
  sched_state_t      next_state;
  logic              trigger;
  logic              eligible;
  logic              in_range;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] tile_code_q;
  logic              unused_px_y_low;

  // Pixel rows inside a cell select the same tile, so the low row bits are not needed here.
  assign unused_px_y_low = ^px_Y[2:0];

  tile_addr_calc #(
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_tile_addr_calc (
    .row  (px_Y[9:3]),
    .col  (px_X[9:3]),
    .addr (fetch_addr)
  );

  assign trigger  = pix_tick & video_on & tile_x_aligned(px_X);
  assign eligible = wr_req & ((WR_BLANK_ONLY == 1'b0) | ~video_on);
  assign in_range = (wr_addr < ADDR_W'(COLS * ROWS));

  // During capture the fresh RAM word is forwarded so tile_code and tile_valid line up.
  assign tile_code = (state == ST_VCAP) ? mem_rdata : tile_code_q;

  // Next-state arbitration: a fetch trigger beats any pending write.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          next_state = ST_VRD;
        end else if (eligible) begin
          next_state = ST_WR;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_VRD: begin
        next_state = ST_VCAP;
      end
      ST_VCAP: begin
        if (trigger) begin
          next_state = ST_VRD;
        end else if (eligible) begin
          next_state = ST_WR;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WR: begin
        if (trigger) begin
          next_state = ST_VRD;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered RAM port and handshake outputs, loaded for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      tile_valid <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      wr_ack     <= 1'b0;
      tile_valid <= 1'b0;
      case (next_state)
        ST_VRD: begin
          mem_addr <= fetch_addr;
        end
        ST_VCAP: begin
          tile_valid <= 1'b1;
        end
        ST_WR: begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
          mem_we    <= in_range;
          wr_ack    <= 1'b1;
          if (!in_range) begin
            wr_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Hold the last fetched tile code until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_code_q <= '0;
    end else if (state == ST_VCAP) begin
      tile_code_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Directed testbench for fb_port_scheduler: a default instance plus a blank-only-write instance.
module tb_fb_port_scheduler;

  logic        clk;
  logic        rst;
  logic        pix_tick;
  logic [9:0]  px_X;
  logic [9:0]  px_Y;
  logic        video_on;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;

  logic        wr_ack, wr_err, mem_we, tile_valid;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, tile_code;

  logic        b_wr_ack, b_mem_we;
  logic        unused_b_wr_err, unused_b_tile_valid;
  logic [12:0] b_mem_addr;
  logic [7:0]  b_mem_wdata, b_mem_rdata, unused_b_tile_code;

  logic [7:0]  ram [0:8191];
  int          checks;
  int          errors;
  int          tv_count;

  fb_port_scheduler dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .px_X(px_X), .px_Y(px_Y),
    .video_on(video_on), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .tile_code(tile_code),
    .tile_valid(tile_valid)
  );

  fb_port_scheduler #(.WR_BLANK_ONLY(1'b1)) dut_blank (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .px_X(px_X), .px_Y(px_Y),
    .video_on(video_on), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(b_wr_ack), .wr_err(unused_b_wr_err), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .tile_code(unused_b_tile_code),
    .tile_valid(unused_b_tile_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_init(input int a);
    if (a == 82) return 8'h35;
    return 8'(a) ^ 8'h5A;
  endfunction

  // Tile-map RAM model: refilled during reset, written by the default instance only.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8192; i++) ram[i] <= ram_init(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata   <= ram[mem_addr];
    b_mem_rdata <= ram[b_mem_addr];
  end

  // Count tile_valid pulses of the default instance.
  always @(negedge clk) begin
    if (tile_valid === 1'b1) tv_count++;
  end

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_we, mem_wdata, wr_ack, wr_err, tile_code, tile_valid} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {mem_addr, mem_we, mem_wdata, wr_ack, wr_err, tile_code, tile_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_ack, tile_valid, mem_we, tile_code} !== 11'd0) begin
      errors++;
      $display("FAIL after_release: got %h expected 0", {wr_ack, tile_valid, mem_we, tile_code});
    end
  endtask

  task automatic test_fetch;
    @(negedge clk);
    pix_tick = 1'b1; video_on = 1'b1; px_X = 10'd16; px_Y = 10'd8;
    @(negedge clk);
    pix_tick = 1'b0; px_X = 10'd17;
    checks++;
    if (mem_addr !== 13'd82 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL fetch_addr: got addr=%0d we=%b expected addr=82 we=0", mem_addr, mem_we);
    end
    @(negedge clk);
    checks++;
    if (tile_valid !== 1'b1 || tile_code !== 8'h35) begin
      errors++;
      $display("FAIL fetch_data: got valid=%b code=%h expected valid=1 code=35", tile_valid, tile_code);
    end
    @(negedge clk);
    checks++;
    if (tile_valid !== 1'b0 || tile_code !== 8'h35) begin
      errors++;
      $display("FAIL fetch_hold: got valid=%b code=%h expected valid=0 code=35", tile_valid, tile_code);
    end
  endtask

  task automatic test_collision;
    @(negedge clk);
    pix_tick = 1'b1; px_X = 10'd24; px_Y = 10'd16;
    wr_req = 1'b1; wr_addr = 13'd5; wr_data = 8'hAA;
    @(negedge clk);
    pix_tick = 1'b0;
    checks++;
    if (mem_addr !== 13'd163 || wr_ack !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL coll_vrd: got addr=%0d ack=%b we=%b expected 163/0/0", mem_addr, wr_ack, mem_we);
    end
    @(negedge clk);
    checks++;
    if (tile_valid !== 1'b1 || tile_code !== ram_init(163) || wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL coll_vcap: got valid=%b code=%h ack=%b expected 1/%h/0",
               tile_valid, tile_code, wr_ack, ram_init(163));
    end
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'd5 || mem_wdata !== 8'hAA ||
        tile_code !== ram_init(163) || tile_valid !== 1'b0) begin
      errors++;
      $display("FAIL coll_wr: got ack=%b we=%b addr=%0d data=%h code=%h expected 1/1/5/aa/%h",
               wr_ack, mem_we, mem_addr, mem_wdata, tile_code, ram_init(163));
    end
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b0 || ram[5] !== 8'hAA) begin
      errors++;
      $display("FAIL coll_done: got ack=%b ram5=%h expected 0/aa", wr_ack, ram[5]);
    end
  endtask

  task automatic test_trigger_during_wr;
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 13'd200; wr_data = 8'h5C;
    @(negedge clk);
    wr_req = 1'b0; pix_tick = 1'b1; px_X = 10'd8; px_Y = 10'd0;
    checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'd200) begin
      errors++;
      $display("FAIL twr_write: got ack=%b we=%b addr=%0d expected 1/1/200", wr_ack, mem_we, mem_addr);
    end
    @(negedge clk);
    pix_tick = 1'b0;
    checks++;
    if (mem_addr !== 13'd1 || wr_ack !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL twr_vrd: got addr=%0d ack=%b we=%b expected 1/0/0", mem_addr, wr_ack, mem_we);
    end
    @(negedge clk);
    checks++;
    if (tile_valid !== 1'b1 || tile_code !== ram_init(1) || ram[200] !== 8'h5C) begin
      errors++;
      $display("FAIL twr_vcap: got valid=%b code=%h ram200=%h expected 1/%h/5c",
               tile_valid, tile_code, ram[200], ram_init(1));
    end
  endtask

  task automatic test_range;
    @(negedge clk);
    video_on = 1'b0; wr_req = 1'b1; wr_addr = 13'd4799; wr_data = 8'h42;
    @(negedge clk);
    wr_req = 1'b0;
    checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || wr_err !== 1'b0 || mem_addr !== 13'd4799) begin
      errors++;
      $display("FAIL range_last: got ack=%b we=%b err=%b addr=%0d expected 1/1/0/4799",
               wr_ack, mem_we, wr_err, mem_addr);
    end
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 13'd4800; wr_data = 8'h77;
    @(negedge clk);
    wr_req = 1'b0;
    checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b0 || wr_err !== 1'b1) begin
      errors++;
      $display("FAIL range_over: got ack=%b we=%b err=%b expected 1/0/1", wr_ack, mem_we, wr_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_err !== 1'b1 || wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL range_sticky: got err=%b ack=%b expected 1/0", wr_err, wr_ack);
    end
  endtask

  task automatic test_blank_only;
    @(negedge clk);
    video_on = 1'b1; wr_req = 1'b1; wr_addr = 13'd7; wr_data = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (b_wr_ack !== 1'b0 || b_mem_we !== 1'b0) begin
        errors++;
        $display("FAIL blank_hold%0d: got ack=%b we=%b expected 0/0", i, b_wr_ack, b_mem_we);
      end
    end
    video_on = 1'b0;
    @(negedge clk);
    checks++;
    if (b_wr_ack !== 1'b1 || b_mem_we !== 1'b1 || b_mem_addr !== 13'd7 || b_mem_wdata !== 8'h3C) begin
      errors++;
      $display("FAIL blank_grant: got ack=%b we=%b addr=%0d data=%h expected 1/1/7/3c",
               b_wr_ack, b_mem_we, b_mem_addr, b_mem_wdata);
    end
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b_wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL blank_drop: got ack=%b expected 0", b_wr_ack);
    end
  endtask

  task automatic test_no_fetch;
    @(negedge clk);
    pix_tick = 1'b1; video_on = 1'b0; px_X = 10'd32; px_Y = 10'd0;
    @(negedge clk);
    pix_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (tile_valid !== 1'b0 || tile_code !== ram_init(1)) begin
      errors++;
      $display("FAIL blank_nofetch: got valid=%b code=%h expected 0/%h", tile_valid, tile_code, ram_init(1));
    end
    pix_tick = 1'b1; video_on = 1'b1; px_X = 10'd13;
    @(negedge clk);
    pix_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (tile_valid !== 1'b0 || tile_code !== ram_init(1)) begin
      errors++;
      $display("FAIL misaligned_nofetch: got valid=%b code=%h expected 0/%h", tile_valid, tile_code, ram_init(1));
    end
    video_on = 1'b0;
  endtask

  task automatic test_reset_mid_wr;
    @(negedge clk);
    video_on = 1'b0; wr_req = 1'b1; wr_addr = 13'd100; wr_data = 8'h11;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_addr, mem_we, mem_wdata, wr_ack, wr_err, tile_code, tile_valid} !== 33'd0) begin
      errors++;
      $display("FAIL reset_mid_wr: got %h expected 0",
               {mem_addr, mem_we, mem_wdata, wr_ack, wr_err, tile_code, tile_valid});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_noack: got ack=%b expected 0", wr_ack);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'd100) begin
      errors++;
      $display("FAIL reset_reserve: got ack=%b we=%b addr=%0d expected 1/1/100", wr_ack, mem_we, mem_addr);
    end
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b0 || ram[100] !== 8'h11 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got ack=%b ram100=%h err=%b expected 0/11/0", wr_ack, ram[100], wr_err);
    end
  endtask

  task automatic test_full_frame;
    int          base;
    int          exp_addr;
    logic [12:0] last_addr;
    base = tv_count;
    last_addr = '0;
    for (int row = 0; row < 60; row++) begin
      for (int col = 0; col < 80; col++) begin
        @(negedge clk);
        pix_tick = 1'b1; video_on = 1'b1; px_X = 10'(col * 8); px_Y = 10'(row * 8);
        @(negedge clk);
        pix_tick = 1'b0;
        exp_addr = row * 80 + col;
        last_addr = mem_addr;
        checks++;
        if (mem_addr !== 13'(exp_addr)) begin
          errors++;
          $display("FAIL frame_addr r%0d c%0d: got %0d expected %0d", row, col, mem_addr, exp_addr);
        end
        @(negedge clk);
        checks++;
        if (tile_valid !== 1'b1 || tile_code !== ram[exp_addr]) begin
          errors++;
          $display("FAIL frame_data r%0d c%0d: got valid=%b code=%h expected 1/%h",
                   row, col, tile_valid, tile_code, ram[exp_addr]);
        end
        @(negedge clk);
      end
    end
    video_on = 1'b0;
    @(negedge clk);
    checks++;
    if (tv_count - base !== 4800) begin
      errors++;
      $display("FAIL frame_count: got %0d expected 4800", tv_count - base);
    end
    checks++;
    if (last_addr !== 13'd4799) begin
      errors++;
      $display("FAIL frame_last: got %0d expected 4799", last_addr);
    end
  endtask

  initial begin
    checks = 0; errors = 0; tv_count = 0;
    rst = 1'b1; pix_tick = 1'b0; px_X = '0; px_Y = '0; video_on = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_collision();
    test_trigger_during_wr();
    test_range();
    test_blank_only();
    test_no_fetch();
    test_reset_mid_wr();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
